// File: rtl/leaf_pkg.sv
// Shared definitions for the leaf egress scheduler: packet field widths and
// bit offsets, the scheduler FSM state type, and the packet packing helper.
package leaf_pkg;

  localparam int unsigned PayloadBits = 32;
  localparam int unsigned LeafBits    = 5;
  localparam int unsigned PortBits    = 4;
  localparam int unsigned AddrBits    = 7;
  localparam int unsigned PacketBits  = 1 + LeafBits + PortBits + AddrBits + PayloadBits;

  // Field offsets within a packet, LSB first.
  localparam int unsigned PayloadLsb = 0;
  localparam int unsigned AddrLsb    = PayloadLsb + PayloadBits;
  localparam int unsigned PortLsb    = AddrLsb + AddrBits;
  localparam int unsigned LeafLsb    = PortLsb + PortBits;
  localparam int unsigned ValidBit   = LeafLsb + LeafBits;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } sched_state_e;

  // Builds a valid packet: {valid, leaf, port, addr, payload}.
  function automatic logic [PacketBits-1:0] pack_pkt(
    input logic [LeafBits-1:0]    leaf,
    input logic [PortBits-1:0]    dport,
    input logic [AddrBits-1:0]    addr,
    input logic [PayloadBits-1:0] word
  );
    return {1'b1, leaf, dport, addr, word};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way combinational round-robin arbiter.
// Ports:
//   req     - per-requester request
//   rr_ptr  - index of the last winner; search starts at rr_ptr+1 (mod N)
//   gnt     - one-hot grant (zero when no request)
//   gnt_idx - binary index of the winner
//   gnt_vld - a grant was issued
module rr_arbiter #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] rr_ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] gnt_idx,
  output logic            gnt_vld
);

  always_comb begin
    int unsigned idx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(rr_ptr) + k) % N;
      if (!gnt_vld && req[IdxW'(idx)]) begin
        gnt_vld           = 1'b1;
        gnt_idx           = IdxW'(idx);
        gnt[IdxW'(idx)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/leaf_out_scheduler.sv
// Credit-based round-robin scheduler multiplexing NUM_OUT_PORTS user output
// streams onto one leaf-to-BFT packet stream. Each word is stamped with its
// route (leaf, port) and a per-stream receiver write address, and a stream is
// never sent more words than its receiver buffer credit allows.
// Ports:
//   clk, reset_n            - clock, async active-low reset
//   ap_start                - pulse, leaves IDLE
//   resend                  - level, suspends granting while high
//   cfg_vld/port/leaf/dport - route configuration write
//   crd_vld/port/cnt        - credit return
//   vld_user2if/din_user2if - user streams, stream i at [i*32 +: 32]
//   ack_if2user             - one-hot accept, same cycle as grant
//   pkt_out/pkt_ready       - registered packet (MSB = valid) and BFT accept
//   crd_err                 - sticky credit overflow
// The field-width parameters must match the leaf_pkg packet layout.
module leaf_out_scheduler
  import leaf_pkg::*;
#(
  parameter int unsigned PACKET_BITS        = leaf_pkg::PacketBits,
  parameter int unsigned PAYLOAD_BITS       = leaf_pkg::PayloadBits,
  parameter int unsigned NUM_LEAF_BITS      = leaf_pkg::LeafBits,
  parameter int unsigned NUM_PORT_BITS      = leaf_pkg::PortBits,
  parameter int unsigned NUM_ADDR_BITS      = leaf_pkg::AddrBits,
  parameter int unsigned NUM_OUT_PORTS      = 2,
  parameter int unsigned NUM_BRAM_ADDR_BITS = 7
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   ap_start,
  input  logic                                   resend,
  input  logic                                   cfg_vld,
  input  logic [2:0]                             cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]               cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]               cfg_dport,
  input  logic                                   crd_vld,
  input  logic [2:0]                             crd_port,
  input  logic [NUM_BRAM_ADDR_BITS:0]            crd_cnt,
  input  logic [NUM_OUT_PORTS-1:0]               vld_user2if,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]  din_user2if,
  output logic [NUM_OUT_PORTS-1:0]               ack_if2user,
  output logic [PACKET_BITS-1:0]                 pkt_out,
  input  logic                                   pkt_ready,
  output logic                                   crd_err
);

  localparam int unsigned IdxW = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int unsigned CrdW = NUM_BRAM_ADDR_BITS + 1;
  localparam logic [CrdW-1:0] CrdFull = {1'b1, {NUM_BRAM_ADDR_BITS{1'b0}}};

  sched_state_e              state_q, state_d;
  logic [IdxW-1:0]           rr_q, rr_d;
  logic [PACKET_BITS-1:0]    pkt_q, pkt_d;
  logic                      err_q, err_d;
  logic [NUM_OUT_PORTS-1:0]  cfgd_q, cfgd_d;
  logic [NUM_LEAF_BITS-1:0]  leaf_q   [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0]  leaf_d   [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0]  dport_q  [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0]  dport_d  [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0]  addr_q   [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0]  addr_d   [NUM_OUT_PORTS];
  logic [CrdW-1:0]           credit_q [NUM_OUT_PORTS];
  logic [CrdW-1:0]           credit_d [NUM_OUT_PORTS];

  logic                      slot_free, grant_en;
  logic [NUM_OUT_PORTS-1:0]  req, gnt;
  logic [IdxW-1:0]           gnt_idx;
  logic                      gnt_vld;
  logic [NUM_LEAF_BITS-1:0]  sel_leaf;
  logic [NUM_PORT_BITS-1:0]  sel_dport;
  logic [NUM_ADDR_BITS-1:0]  sel_addr;
  logic [PAYLOAD_BITS-1:0]   sel_word;

  // The output slot is free when empty or being drained this cycle.
  assign slot_free = ~pkt_q[PACKET_BITS-1] | pkt_ready;
  // resend masks grants immediately, including the cycle it rises in RUN.
  assign grant_en  = (state_q == RUN) & ~resend & slot_free;

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      req[i] = grant_en & cfgd_q[i] & vld_user2if[i] & (credit_q[i] != '0);
    end
  end

  rr_arbiter #(
    .N    (NUM_OUT_PORTS),
    .IdxW (IdxW)
  ) u_rr_arbiter (
    .req     (req),
    .rr_ptr  (rr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign ack_if2user = gnt;
  assign pkt_out     = pkt_q;
  assign crd_err     = err_q;

  // One-hot select of the granted stream's route, address and word.
  always_comb begin
    sel_leaf  = '0;
    sel_dport = '0;
    sel_addr  = '0;
    sel_word  = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (gnt[i]) begin
        sel_leaf  = leaf_q[i];
        sel_dport = dport_q[i];
        sel_addr  = addr_q[i];
        sel_word  = din_user2if[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ap_start) state_d = RUN;
      RUN:     if (resend) state_d = HOLD;
      HOLD:    if (!resend) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    logic [CrdW:0] sum;
    pkt_d  = pkt_q;
    err_d  = err_q;
    rr_d   = rr_q;
    cfgd_d = cfgd_q;
    sum    = '0;

    if (gnt_vld) begin
      pkt_d = PACKET_BITS'(pack_pkt(sel_leaf, sel_dport, sel_addr, sel_word));
      rr_d  = gnt_idx;
    end else if (pkt_ready) begin
      pkt_d = '0;
    end

    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      leaf_d[i]  = leaf_q[i];
      dport_d[i] = dport_q[i];
      addr_d[i]  = addr_q[i];

      // Grants require credit != 0, so the decrement cannot underflow.
      sum = {1'b0, credit_q[i]};
      if (gnt[i]) begin
        sum       = sum - {{CrdW{1'b0}}, 1'b1};
        addr_d[i] = addr_q[i] + {{(NUM_ADDR_BITS-1){1'b0}}, 1'b1};
      end
      if (crd_vld && (int'(crd_port) == i)) begin
        sum = sum + {1'b0, crd_cnt};
      end
      if (sum > {1'b0, CrdFull}) begin
        credit_d[i] = CrdFull;
        err_d       = 1'b1;
      end else begin
        credit_d[i] = sum[CrdW-1:0];
      end

      // A config write lands after any same-cycle grant on that stream.
      if (cfg_vld && (int'(cfg_port) == i)) begin
        leaf_d[i]   = cfg_leaf;
        dport_d[i]  = cfg_dport;
        cfgd_d[i]   = 1'b1;
        addr_d[i]   = '0;
        credit_d[i] = CrdFull;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      pkt_q   <= '0;
      err_q   <= 1'b0;
      cfgd_q  <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        leaf_q[i]   <= '0;
        dport_q[i]  <= '0;
        addr_q[i]   <= '0;
        credit_q[i] <= CrdFull;
      end
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
      cfgd_q  <= cfgd_d;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        leaf_q[i]   <= leaf_d[i];
        dport_q[i]  <= dport_d[i];
        addr_q[i]   <= addr_d[i];
        credit_q[i] <= credit_d[i];
      end
    end
  end

endmodule

// File: tb/tb_leaf_out_scheduler.sv
module tb_leaf_out_scheduler;

  localparam int N  = 2;
  localparam int PW = 49;

  logic            clk, reset_n, ap_start, resend;
  logic            cfg_vld, crd_vld, pkt_ready, crd_err;
  logic [2:0]      cfg_port, crd_port;
  logic [4:0]      cfg_leaf;
  logic [3:0]      cfg_dport;
  logic [7:0]      crd_cnt;
  logic [N-1:0]    vld_user2if, ack_if2user;
  logic [N*32-1:0] din_user2if;
  logic [PW-1:0]   pkt_out;

  int n_checks, n_pass;

  leaf_out_scheduler #(
    .NUM_OUT_PORTS (N)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ap_start    (ap_start),
    .resend      (resend),
    .cfg_vld     (cfg_vld),
    .cfg_port    (cfg_port),
    .cfg_leaf    (cfg_leaf),
    .cfg_dport   (cfg_dport),
    .crd_vld     (crd_vld),
    .crd_port    (crd_port),
    .crd_cnt     (crd_cnt),
    .vld_user2if (vld_user2if),
    .din_user2if (din_user2if),
    .ack_if2user (ack_if2user),
    .pkt_out     (pkt_out),
    .pkt_ready   (pkt_ready),
    .crd_err     (crd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam int MIdle = 0, MRun = 1, MHold = 2;
  int            m_state, m_rr;
  logic [PW-1:0] m_pkt;
  logic          m_err;
  logic          m_cfgd   [N];
  logic [4:0]    m_leaf   [N];
  logic [3:0]    m_dport  [N];
  int            m_addr   [N];
  int            m_credit [N];

  function automatic logic [PW-1:0] pk(input int leaf, input int dport, input int addr,
                                       input logic [31:0] word);
    return {1'b1, 5'(leaf), 4'(dport), 7'(addr), word};
  endfunction

  task automatic model_reset();
    m_state = MIdle;
    m_rr    = 0;
    m_pkt   = '0;
    m_err   = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_cfgd[i]   = 1'b0;
      m_leaf[i]   = '0;
      m_dport[i]  = '0;
      m_addr[i]   = 0;
      m_credit[i] = 128;
    end
  endtask

  function automatic int model_grant();
    int idx;
    if (m_state != MRun || resend) return -1;
    if (m_pkt[PW-1] && !pkt_ready) return -1;
    for (int k = 1; k <= N; k++) begin
      idx = (m_rr + k) % N;
      if (m_cfgd[idx] && vld_user2if[idx] && m_credit[idx] > 0) return idx;
    end
    return -1;
  endfunction

  task automatic model_tick(input int g);
    logic [PW-1:0] np;
    int c;
    np = m_pkt;
    if (g >= 0) np = pk(int'(m_leaf[g]), int'(m_dport[g]), m_addr[g], din_user2if[g*32 +: 32]);
    else if (pkt_ready) np = '0;
    for (int i = 0; i < N; i++) begin
      c = m_credit[i] - ((g == i) ? 1 : 0)
          + ((crd_vld && int'(crd_port) == i) ? int'(crd_cnt) : 0);
      if (c > 128) begin
        c     = 128;
        m_err = 1'b1;
      end
      m_credit[i] = c;
    end
    if (g >= 0) begin
      m_addr[g] = (m_addr[g] + 1) % 128;
      m_rr      = g;
    end
    if (cfg_vld && int'(cfg_port) < N) begin
      m_leaf[cfg_port]   = cfg_leaf;
      m_dport[cfg_port]  = cfg_dport;
      m_cfgd[cfg_port]   = 1'b1;
      m_addr[cfg_port]   = 0;
      m_credit[cfg_port] = 128;
    end
    case (m_state)
      MIdle:   if (ap_start) m_state = MRun;
      MRun:    if (resend) m_state = MHold;
      default: if (!resend) m_state = MRun;
    endcase
    m_pkt = np;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_inputs();
    ap_start    = 1'b0;
    resend      = 1'b0;
    cfg_vld     = 1'b0;
    cfg_port    = '0;
    cfg_leaf    = '0;
    cfg_dport   = '0;
    crd_vld     = 1'b0;
    crd_port    = '0;
    crd_cnt     = '0;
    vld_user2if = '0;
    din_user2if = '0;
    pkt_ready   = 1'b1;
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic cycle();
    int g;
    #1;
    g = model_grant();
    check("ack", 64'(ack_if2user), (g < 0) ? 64'd0 : (64'd1 << g));
    check("pkt_out", 64'(pkt_out), 64'(m_pkt));
    check("crd_err", 64'(crd_err), 64'(m_err));
    model_tick(g);
    @(negedge clk);
  endtask

  typedef struct {
    logic          cfg_vld;
    logic [2:0]    cfg_port;
    logic [4:0]    cfg_leaf;
    logic [3:0]    cfg_dport;
    logic          ap_start;
    logic [1:0]    vld;
    logic [31:0]   d0;
    logic [31:0]   d1;
    logic          ready;
    logic [1:0]    exp_ack;
    logic [PW-1:0] exp_pkt;
  } vec_t;

  vec_t vecs[10];
  int   n0;
  logic [PW-1:0] cap;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clear_inputs();
    model_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pkt", 64'(pkt_out), 64'd0);
    check("rst_ack", 64'(ack_if2user), 64'd0);
    check("rst_err", 64'(crd_err), 64'd0);
    reset_n = 1'b1;

    // Basic sequence: config, start, one word, then alternating round robin.
    vecs[0] = '{1'b1, 3'd0, 5'd3, 4'd2, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, '0};
    vecs[1] = '{1'b1, 3'd1, 5'd7, 4'd9, 1'b1, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, '0};
    vecs[2] = '{1'b0, 3'd0, 5'd0, 4'd0, 1'b0, 2'b01, 32'hA5A5A5A5, 32'h0, 1'b1, 2'b01, '0};
    vecs[3] = '{1'b0, 3'd0, 5'd0, 4'd0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00,
                pk(3, 2, 0, 32'hA5A5A5A5)};
    vecs[4] = '{1'b0, 3'd0, 5'd0, 4'd0, 1'b0, 2'b11, 32'h11111111, 32'h22222222, 1'b1, 2'b10,
                '0};
    vecs[5] = '{1'b0, 3'd0, 5'd0, 4'd0, 1'b0, 2'b11, 32'h33333333, 32'h44444444, 1'b1, 2'b01,
                pk(7, 9, 0, 32'h22222222)};
    vecs[6] = '{1'b0, 3'd0, 5'd0, 4'd0, 1'b0, 2'b11, 32'h55555555, 32'h66666666, 1'b1, 2'b10,
                pk(3, 2, 1, 32'h33333333)};
    vecs[7] = '{1'b0, 3'd0, 5'd0, 4'd0, 1'b0, 2'b11, 32'h77777777, 32'h88888888, 1'b1, 2'b01,
                pk(7, 9, 1, 32'h66666666)};
    vecs[8] = '{1'b0, 3'd0, 5'd0, 4'd0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00,
                pk(3, 2, 2, 32'h77777777)};
    vecs[9] = '{1'b0, 3'd0, 5'd0, 4'd0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, '0};

    for (int v = 0; v < 10; v++) begin
      cfg_vld     = vecs[v].cfg_vld;
      cfg_port    = vecs[v].cfg_port;
      cfg_leaf    = vecs[v].cfg_leaf;
      cfg_dport   = vecs[v].cfg_dport;
      ap_start    = vecs[v].ap_start;
      vld_user2if = vecs[v].vld;
      din_user2if = {vecs[v].d1, vecs[v].d0};
      pkt_ready   = vecs[v].ready;
      #1;
      check("tbl_ack", 64'(ack_if2user), 64'(vecs[v].exp_ack));
      check("tbl_pkt", 64'(pkt_out), 64'(vecs[v].exp_pkt));
      cycle();
    end
    clear_inputs();

    // Credit exhaustion on port 0, address wrap, credit return resumes.
    cfg_vld = 1'b1; cfg_port = 3'd0; cfg_leaf = 5'd3; cfg_dport = 4'd2;
    cycle();
    clear_inputs();
    n0 = 0;
    for (int k = 0; k < 130; k++) begin
      vld_user2if = 2'b01;
      din_user2if = {32'h0, 32'(k)};
      #1;
      if (ack_if2user[0]) n0++;
      cycle();
    end
    check("credit_stop", 64'(n0), 64'd128);
    crd_vld = 1'b1; crd_port = 3'd0; crd_cnt = 8'd64;
    cycle();
    crd_vld = 1'b0;
    #1;
    check("credit_resume", 64'(ack_if2user), 64'd1);
    cycle();
    #1;
    check("addr_wrap", 64'(pkt_out[38:32]), 64'd0);
    check("addr_wrap_vld", 64'(pkt_out[PW-1]), 64'd1);
    cycle();

    // Back-pressure: pkt_out held and no acks while pkt_ready is low.
    pkt_ready = 1'b0;
    #1;
    cap = pkt_out;
    check("bp_valid", 64'(cap[PW-1]), 64'd1);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_hold", 64'(pkt_out), 64'(cap));
      check("bp_ack", 64'(ack_if2user), 64'd0);
      cycle();
    end
    pkt_ready = 1'b1;
    #1;
    check("bp_resume", 64'(ack_if2user), 64'd1);
    cycle();

    // resend mid-stream: held packet drains, no grants until RUN again.
    vld_user2if = 2'b11;
    din_user2if = {32'hBEEF0001, 32'hCAFE0001};
    cycle();
    pkt_ready = 1'b0;
    cycle();
    pkt_ready = 1'b1;
    resend    = 1'b1;
    #1;
    check("rs_drain_vld", 64'(pkt_out[PW-1]), 64'd1);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rs_noack", 64'(ack_if2user), 64'd0);
      cycle();
    end
    check("rs_empty", 64'(pkt_out), 64'd0);
    resend = 1'b0;
    cycle();
    #1;
    check("rs_regrant", 64'(ack_if2user != 0), 64'd1);
    cycle();
    clear_inputs();

    // Credit overflow sets sticky crd_err; async reset mid-burst clears all.
    cfg_vld = 1'b1; cfg_port = 3'd1; cfg_leaf = 5'd4; cfg_dport = 4'd5;
    cycle();
    clear_inputs();
    crd_vld = 1'b1; crd_port = 3'd1; crd_cnt = 8'd128;
    cycle();
    clear_inputs();
    #1;
    check("ovf_err", 64'(crd_err), 64'd1);
    cycle();
    vld_user2if = 2'b11;
    din_user2if = {32'h12345678, 32'h9ABCDEF0};
    cycle();
    cycle();
    #2;
    check("pre_rst_vld", 64'(pkt_out[PW-1]), 64'd1);
    reset_n = 1'b0;
    #1;
    check("arst_pkt", 64'(pkt_out), 64'd0);
    check("arst_ack", 64'(ack_if2user), 64'd0);
    check("arst_err", 64'(crd_err), 64'd0);
    model_reset();
    clear_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    cycle();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      ap_start    = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 39) == 0) resend = ~resend;
      cfg_vld     = ($urandom_range(0, 19) == 0);
      cfg_port    = 3'($urandom_range(0, 3));
      cfg_leaf    = 5'($urandom);
      cfg_dport   = 4'($urandom);
      crd_vld     = !cfg_vld && ($urandom_range(0, 7) == 0);
      crd_port    = 3'($urandom_range(0, 2));
      crd_cnt     = 8'($urandom_range(0, 6));
      vld_user2if = N'($urandom_range(0, 3));
      din_user2if = {$urandom, $urandom};
      pkt_ready   = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
